// File: rtl/adam_apb_timer.sv
// adam_apb_timer - APB slave timer peripheral.
//
// A prescaled up-counter with a compare match, auto-reload or one-shot mode,
// a level interrupt and byte-strobed register access. The block joins the
// system pause protocol: on request it lets the current APB access phase
// finish, then freezes all counting and stalls further transfers.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   test       test mode (no functional effect)
//   pause_req  pause request
//   pause_ack  pause acknowledge (high while frozen, high out of reset)
//   paddr, pprot, psel, penable, pwrite, pwdata, pstrb  APB request
//   pready, prdata, pslverr                            APB response
//   irq        level interrupt = STATUS.MATCH & CTRL.IRQ_EN
//
// Register map (offset decoded on paddr[4:2]):
//   0x00 CTRL     bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN
//   0x04 PRESC    prescaler terminal value
//   0x08 VALUE    counter
//   0x0C COMPARE  match value
//   0x10 STATUS   bit0 MATCH, write-1-to-clear
//   0x14..0x1C    unmapped -> pslverr

module adam_apb_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  test,
    input  logic                  pause_req,
    output logic                  pause_ack,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [2:0]            pprot,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0] pstrb,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  irq
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_e;

    localparam logic [2:0] OFS_CTRL    = 3'd0;
    localparam logic [2:0] OFS_PRESC   = 3'd1;
    localparam logic [2:0] OFS_VALUE   = 3'd2;
    localparam logic [2:0] OFS_COMPARE = 3'd3;
    localparam logic [2:0] OFS_STATUS  = 3'd4;

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Merge write data into an existing word, one byte lane per strobe bit.
    function automatic logic [DATA_WIDTH-1:0] apply_strb(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    state_e                state_q, state_d;
    logic [2:0]            ctrl_q, ctrl_d, ctrl_hw_s;
    logic [DATA_WIDTH-1:0] presc_q, presc_d;
    logic [DATA_WIDTH-1:0] value_q, value_d, value_hw_s;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic [DATA_WIDTH-1:0] pcnt_q, pcnt_d, pcnt_hw_s;
    logic                  match_q, match_d, match_set_s;

    logic       access_s;
    logic       xfer_s;
    logic       mapped_s;
    logic       wr_s;
    logic [2:0] ofs_s;
    logic       count_s;
    logic       tick_s;
    logic       hit_s;
    logic       unused_s;

    assign ofs_s    = paddr[4:2];
    assign access_s = psel & penable;
    assign mapped_s = (ofs_s <= OFS_STATUS);

    // pause_ack is a pure decode of the state register.
    assign pause_ack = (state_q == ST_PAUSED);
    assign pready    = access_s & ~pause_ack;
    assign xfer_s    = pready;
    assign wr_s      = xfer_s & pwrite & mapped_s;
    assign pslverr   = xfer_s & ~mapped_s;
    assign irq       = match_q & ctrl_q[2];

    assign count_s = (state_q == ST_RUN) & ctrl_q[0];
    assign tick_s  = count_s & (pcnt_q == presc_q);
    assign hit_s   = (value_q == compare_q);

    assign unused_s = ^{test, pprot, paddr[ADDR_WIDTH-1:5], paddr[1:0]};

    // Pause FSM: never freeze in the middle of an access phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (pause_req && !access_s) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (!pause_req) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: state_d = ST_PAUSED;
        endcase
    end

    // Hardware-only next state of the counter datapath (before APB writes).
    always_comb begin
        ctrl_hw_s   = ctrl_q;
        value_hw_s  = value_q;
        pcnt_hw_s   = pcnt_q;
        match_set_s = 1'b0;
        if (tick_s) begin
            pcnt_hw_s = '0;
            if (hit_s) begin
                match_set_s = 1'b1;
                if (ctrl_q[1]) begin
                    value_hw_s = '0;
                end else begin
                    // One-shot: hold the value and stop.
                    value_hw_s   = value_q;
                    ctrl_hw_s[0] = 1'b0;
                end
            end else begin
                value_hw_s = value_q + ONE;
            end
        end else if (count_s) begin
            pcnt_hw_s = pcnt_q + ONE;
        end else begin
            pcnt_hw_s = pcnt_q;
        end
    end

    // APB writes layered on top of the hardware update; writes win except
    // for MATCH, where a hardware set beats a simultaneous clear.
    always_comb begin
        ctrl_d    = ctrl_hw_s;
        presc_d   = presc_q;
        value_d   = value_hw_s;
        compare_d = compare_q;
        pcnt_d    = pcnt_hw_s;
        match_d   = match_q;
        if (wr_s) begin
            case (ofs_s)
                OFS_CTRL: begin
                    if (pstrb[0]) begin
                        ctrl_d = pwdata[2:0];
                    end else begin
                        ctrl_d = ctrl_hw_s;
                    end
                end
                OFS_PRESC: begin
                    presc_d = apply_strb(presc_q, pwdata, pstrb);
                    pcnt_d  = '0;
                end
                OFS_VALUE: begin
                    value_d = apply_strb(value_hw_s, pwdata, pstrb);
                    pcnt_d  = '0;
                end
                OFS_COMPARE: begin
                    compare_d = apply_strb(compare_q, pwdata, pstrb);
                end
                OFS_STATUS: begin
                    if (pstrb[0] && pwdata[0]) begin
                        match_d = 1'b0;
                    end else begin
                        match_d = match_q;
                    end
                end
                default: begin
                    ctrl_d = ctrl_hw_s;
                end
            endcase
        end else begin
            ctrl_d = ctrl_hw_s;
        end
        if (match_set_s) begin
            match_d = 1'b1;
        end else begin
            match_d = match_d;
        end
    end

    // Read mux: data only while the transfer completes, zero otherwise.
    always_comb begin
        prdata = '0;
        if (xfer_s) begin
            case (ofs_s)
                OFS_CTRL:    prdata = {{(DATA_WIDTH-3){1'b0}}, ctrl_q};
                OFS_PRESC:   prdata = presc_q;
                OFS_VALUE:   prdata = value_q;
                OFS_COMPARE: prdata = compare_q;
                OFS_STATUS:  prdata = {{(DATA_WIDTH-1){1'b0}}, match_q};
                default:     prdata = '0;
            endcase
        end else begin
            prdata = '0;
        end
    end

    // State and register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_PAUSED;
            ctrl_q    <= 3'b000;
            presc_q   <= '0;
            value_q   <= '0;
            compare_q <= '0;
            pcnt_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            value_q   <= value_d;
            compare_q <= compare_d;
            pcnt_q    <= pcnt_d;
            match_q   <= match_d;
        end
    end

endmodule

// File: tb/tb_adam_apb_timer.sv
module tb_adam_apb_timer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    localparam logic [31:0] A_CTRL  = 32'h00;
    localparam logic [31:0] A_PRESC = 32'h04;
    localparam logic [31:0] A_VALUE = 32'h08;
    localparam logic [31:0] A_CMP   = 32'h0C;
    localparam logic [31:0] A_STAT  = 32'h10;

    logic          clk = 1'b0;
    logic          rst;
    logic          test;
    logic          pause_req;
    logic          pause_ack;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adam_apb_timer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .test(test),
        .pause_req(pause_req), .pause_ack(pause_ack),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr), .irq(irq)
    );

    // One APB transfer. Entered and left at posedge+1. The access-phase
    // response is sampled at negedge; a missing pready is bounded.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        logic ok;
        ok = 1'b0; rdata = 32'h0; err = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (pready === 1'b1) begin
                rdata = prdata; err = pslverr; ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL apb_timeout addr=%h got pready=0 want pready=1 within 200 cycles", addr);
        end
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d; logic e;
        apb_xfer(1'b1, addr, data, 4'hF, d, e);
    endtask

    // Quiesce and load a fresh configuration with the counter stopped at 0.
    task automatic timer_setup(input logic [31:0] presc, input logic [31:0] cmp);
        wr32(A_CTRL, 32'h0);
        wr32(A_STAT, 32'h1);
        wr32(A_VALUE, 32'h0);
        wr32(A_PRESC, presc);
        wr32(A_CMP, cmp);
    endtask

    // Reference: counter state n clock edges after EN was written, from
    // tick count arithmetic (ticks = n / (PRESC+1)).
    function automatic logic [31:0] ref_value(int n, int p, int c, logic auto_rl);
        int t;
        t = n / (p + 1);
        if (auto_rl) return 32'(t % (c + 1));
        return 32'((t < c) ? t : c);
    endfunction

    function automatic logic ref_match(int n, int p, int c);
        return ((n / (p + 1)) >= (c + 1));
    endfunction

    task automatic test_reset();
        logic [31:0] d; logic e;
        logic [31:0] addrs [5];
        addrs = '{A_CTRL, A_PRESC, A_VALUE, A_CMP, A_STAT};
        rst = 1'b0; test = 1'b0; pause_req = 1'b0; pprot = 3'b000;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pause_ack !== 1'b1 || pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got ack=%b rdy=%b rd=%h err=%b irq=%b want 1 0 0 0 0",
                     pause_ack, pready, prdata, pslverr, irq);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pause_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_unpause got pause_ack=%b want 0", pause_ack);
        end
        for (int i = 0; i < 5; i++) begin
            apb_xfer(1'b0, addrs[i], 32'h0, 4'h0, d, e);
            checks++;
            if (d !== 32'h0 || e !== 1'b0) begin
                failures++;
                $display("FAIL reset_reg addr=%h got %h err=%b want 00000000 err=0", addrs[i], d, e);
            end
        end
    endtask

    task automatic test_strobe_unmapped();
        logic [31:0] d; logic e;
        apb_xfer(1'b1, A_CMP, 32'hDEADBEEF, 4'b0101, d, e);
        apb_xfer(1'b0, A_CMP, 32'h0, 4'h0, d, e);
        checks++;
        if (d !== 32'h00AD00EF) begin
            failures++;
            $display("FAIL strobe_compare got %h want 00ad00ef", d);
        end
        apb_xfer(1'b0, 32'h18, 32'h0, 4'h0, d, e);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_read got err=%b rd=%h want err=1 rd=0", e, d);
        end
        apb_xfer(1'b1, 32'h14, 32'h12345678, 4'hF, d, e);
        checks++;
        if (e !== 1'b1) begin
            failures++;
            $display("FAIL unmapped_write_err got %b want 1", e);
        end
        apb_xfer(1'b0, A_CMP, 32'h0, 4'h0, d, e);
        checks++;
        if (d !== 32'h00AD00EF) begin
            failures++;
            $display("FAIL unmapped_write_discard got %h want 00ad00ef", d);
        end
    endtask

    task automatic test_regs_random();
        logic [31:0] d; logic e;
        logic [31:0] mdl [3];
        logic [31:0] addrs [3];
        logic [31:0] wd;
        logic [3:0]  st;
        int          idx;
        addrs = '{A_PRESC, A_VALUE, A_CMP};
        wr32(A_CTRL, 32'h0);
        for (int i = 0; i < 3; i++) begin
            wr32(addrs[i], 32'h0);
            mdl[i] = 32'h0;
        end
        for (int i = 0; i < 12; i++) begin
            idx = $urandom_range(0, 2);
            wd  = $urandom;
            st  = 4'($urandom_range(0, 15));
            apb_xfer(1'b1, addrs[idx], wd, st, d, e);
            for (int b = 0; b < 4; b++) begin
                if (st[b]) mdl[idx][b*8 +: 8] = wd[b*8 +: 8];
            end
            apb_xfer(1'b0, addrs[idx], 32'h0, 4'h0, d, e);
            checks++;
            if (d !== mdl[idx]) begin
                failures++;
                $display("FAIL reg_rand addr=%h strb=%b got %h want %h", addrs[idx], st, d, mdl[idx]);
            end
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] d; logic e;
        timer_setup(32'd3, 32'd4);
        wr32(A_CTRL, 32'h7);
        repeat (19) @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL auto_irq_early got %b want 0 after 19 cycles", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL auto_irq_rise got %b want 1 after 20 cycles", irq);
        end
        apb_xfer(1'b0, A_STAT, 32'h0, 4'h0, d, e);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL auto_status got %h want 1", d);
        end
        apb_xfer(1'b0, A_VALUE, 32'h0, 4'h0, d, e);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL auto_reload_value got %h want 0", d);
        end
        repeat (8) @(posedge clk); #1;
        apb_xfer(1'b0, A_VALUE, 32'h0, 4'h0, d, e);
        checks++;
        if (d !== 32'h3) begin
            failures++;
            $display("FAIL auto_recount got %h want 3", d);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL auto_irq_held got %b want 1", irq);
        end
        wr32(A_STAT, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL auto_w1c_irq got %b want 0", irq);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d; logic e;
        timer_setup(32'd0, 32'd2);
        wr32(A_CTRL, 32'h1);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_irq got %b want 0", irq);
        end
        apb_xfer(1'b0, A_STAT, 32'h0, 4'h0, d, e);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL oneshot_match got %h want 1", d);
        end
        apb_xfer(1'b0, A_CTRL, 32'h0, 4'h0, d, e);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL oneshot_en got %h want 0", d);
        end
        apb_xfer(1'b0, A_VALUE, 32'h0, 4'h0, d, e);
        checks++;
        if (d !== 32'h2) begin
            failures++;
            $display("FAIL oneshot_value got %h want 2", d);
        end
    endtask

    task automatic test_count_random();
        logic [31:0] d; logic e;
        int p, c, k;
        logic auto_rl, ie, m;
        for (int it = 0; it < 8; it++) begin
            p = $urandom_range(0, 3);
            c = $urandom_range(0, 5);
            k = $urandom_range(0, 30);
            auto_rl = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            timer_setup(32'(p), 32'(c));
            wr32(A_CTRL, {29'h0, ie, auto_rl, 1'b1});
            repeat (k) @(posedge clk);
            #1;
            apb_xfer(1'b0, A_VALUE, 32'h0, 4'h0, d, e);
            checks++;
            if (d !== ref_value(k + 1, p, c, auto_rl)) begin
                failures++;
                $display("FAIL rand_value p=%0d c=%0d k=%0d auto=%b got %h want %h",
                         p, c, k, auto_rl, d, ref_value(k + 1, p, c, auto_rl));
            end
            apb_xfer(1'b0, A_STAT, 32'h0, 4'h0, d, e);
            checks++;
            if (d !== {31'h0, ref_match(k + 3, p, c)}) begin
                failures++;
                $display("FAIL rand_match p=%0d c=%0d k=%0d got %h want %0d", p, c, k, d, ref_match(k + 3, p, c));
            end
            apb_xfer(1'b0, A_CTRL, 32'h0, 4'h0, d, e);
            m = ref_match(k + 5, p, c);
            checks++;
            if (d !== {29'h0, ie, auto_rl, (auto_rl | ~m)}) begin
                failures++;
                $display("FAIL rand_ctrl p=%0d c=%0d k=%0d got %h want %h",
                         p, c, k, d, {29'h0, ie, auto_rl, (auto_rl | ~m)});
            end
            checks++;
            if (irq !== (ref_match(k + 6, p, c) & ie)) begin
                failures++;
                $display("FAIL rand_irq got %b want %b", irq, ref_match(k + 6, p, c) & ie);
            end
        end
    endtask

    task automatic test_pause();
        logic [31:0] d; logic e;
        timer_setup(32'd0, 32'hFFFF_FFFF);
        wr32(A_CTRL, 32'h3);
        // Access phase with pause_req raised alongside penable.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_CTRL; pstrb = 4'h0;
        @(posedge clk); #1;
        penable = 1'b1; pause_req = 1'b1;
        @(negedge clk);
        checks++;
        if (pready !== 1'b1 || prdata !== 32'h3) begin
            failures++;
            $display("FAIL pause_drain got rdy=%b rd=%h want rdy=1 rd=3", pready, prdata);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        checks++;
        if (pause_ack !== 1'b0) begin
            failures++;
            $display("FAIL pause_ack_early got %b want 0", pause_ack);
        end
        @(posedge clk); #1;
        checks++;
        if (pause_ack !== 1'b1) begin
            failures++;
            $display("FAIL pause_ack_rise got %b want 1", pause_ack);
        end
        // Counter ran for three edges before freezing: VALUE is 3.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_VALUE;
        @(posedge clk); #1;
        penable = 1'b1;
        d = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pready !== 1'b0) d = 32'h1;
            @(posedge clk); #1;
        end
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL pause_stall got pready=1 want pready=0 while paused");
        end
        pause_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pause_ack !== 1'b0) begin
            failures++;
            $display("FAIL pause_release got ack=%b want 0", pause_ack);
        end
        @(negedge clk);
        checks++;
        if (pready !== 1'b1 || prdata !== 32'h3) begin
            failures++;
            $display("FAIL pause_frozen got rdy=%b value=%h want rdy=1 value=3", pready, prdata);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_collision();
        logic [31:0] d; logic e;
        // VALUE write landing on a tick edge (PRESC=3: ticks at edges 4, 8, ...).
        timer_setup(32'd3, 32'hFFFF_FFFF);
        wr32(A_CTRL, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        wr32(A_VALUE, 32'h10);
        apb_xfer(1'b0, A_VALUE, 32'h0, 4'h0, d, e);
        checks++;
        if (d !== 32'h10) begin
            failures++;
            $display("FAIL coll_value got %h want 00000010", d);
        end
        // W1C landing on a match edge (PRESC=0, COMPARE=3: matches at edges 4, 8, ...).
        timer_setup(32'd0, 32'd3);
        wr32(A_CTRL, 32'h3);
        repeat (6) @(posedge clk);
        #1;
        wr32(A_STAT, 32'h1);
        apb_xfer(1'b0, A_STAT, 32'h0, 4'h0, d, e);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL coll_match got %h want 1", d);
        end
    endtask

    task automatic test_reset_midxfer();
        wr32(A_CTRL, 32'h0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_CTRL;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (pready !== 1'b0 || pause_ack !== 1'b1 || prdata !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_midxfer got rdy=%b ack=%b rd=%h irq=%b want 0 1 0 0", pready, pause_ack, prdata, irq);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_strobe_unmapped();
        test_regs_random();
        test_autoreload();
        test_oneshot();
        test_count_random();
        test_pause();
        test_collision();
        test_reset_midxfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
